mult_arbiter: RTL and testbench

Round-robin arbiter and pipeline controller that shares one `multiplier` instance (SIZE-bit × SIZE-bit → 2·SIZE-bit) among NUM_REQ requesters in the FPU. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle and registers operands and product in a short pipeline. It returns each product tagged with the requester ID through a single valid/ready result port with full backpressure.

---
 rtl/mult_arb_pkg.sv | 30 +++
 rtl/multiplier.sv | 12 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/mult_arbiter.sv | 147 ++++++++++++++
 tb/tb_mult_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the
// multiplier arbiter.
package mult_arb_pkg;

    localparam int MULT_SIZE    = 24;
    localparam int MULT_NUM_REQ = 4;
    localparam int MULT_ID_W    = $clog2(MULT_NUM_REQ);
    localparam int RR_MAX_REQ   = 32;

    typedef struct packed {
        logic [MULT_SIZE-1:0] a;
        logic [MULT_SIZE-1:0] b;
        logic [MULT_ID_W-1:0] id;
    } mult_req_t;

    // First set bit at or after ptr+1 (mod n); -1 when nothing is requesting.
    // Walks from farthest to nearest so the nearest hit is the one that sticks.
    function automatic int rr_next(input logic [RR_MAX_REQ-1:0] req,
                                   input int ptr, input int n);
        int idx;
        rr_next = -1;
        for (int k = RR_MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                idx = (ptr + k) % n;
                if (req[idx]) rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/multiplier.sv
// Unsigned SIZE x SIZE -> 2*SIZE combinational multiplier shared by the FPU.
module multiplier #(
    parameter int SIZE = 24
) (
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic [2*SIZE-1:0] p
);

    assign p = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant generator; the pointer only moves on a completed handshake.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = MULT_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_id_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    int              pick;

    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        pick       = rr_next(RR_MAX_REQ'(req_i), int'(ptr_q), NUM_REQ);
        if (pick >= 0) begin
            grant_id_o          = ID_W'(pick);
            grant_o[grant_id_o] = 1'b1;
        end
        ptr_d = accept_i ? grant_id_o : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= ID_W'(NUM_REQ - 1);
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one multiplier among NUM_REQ requesters: arbitrate -> S1 -> (S1b) -> S2.
// Define MULT_ARBITER_PIPE_EN to add the S1b register after the multiplier.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int SIZE    = MULT_SIZE,
    parameter int NUM_REQ = MULT_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*SIZE-1:0] req_a,
    input  logic [NUM_REQ*SIZE-1:0] req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*SIZE-1:0]       res_out,
    output logic [ID_W-1:0]         res_id
);

    logic                s1_valid_q, s1_valid_d;
    logic [SIZE-1:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [ID_W-1:0]     s1_id_q, s1_id_d;
    logic                res_valid_q, res_valid_d;
    logic [2*SIZE-1:0]   res_out_q, res_out_d;
    logic [ID_W-1:0]     res_id_q, res_id_d;

    logic [2*SIZE-1:0]   prod;
    logic                s2_src_valid;
    logic [2*SIZE-1:0]   s2_src_p;
    logic [ID_W-1:0]     s2_src_id;
    logic                s2_load, s1_leave, s1_free, accept;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_id;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_valid),
        .accept_i   (accept),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    multiplier #(.SIZE(SIZE)) u_mult (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (prod)
    );

`ifdef MULT_ARBITER_PIPE_EN
    logic              s1b_valid_q, s1b_valid_d;
    logic [2*SIZE-1:0] s1b_p_q, s1b_p_d;
    logic [ID_W-1:0]   s1b_id_q, s1b_id_d;

    assign s1_leave     = s1_valid_q & (!s1b_valid_q | s2_load);
    assign s2_src_valid = s1b_valid_q;
    assign s2_src_p     = s1b_p_q;
    assign s2_src_id    = s1b_id_q;

    always_comb begin
        s1b_valid_d = s1b_valid_q;
        s1b_p_d     = s1b_p_q;
        s1b_id_d    = s1b_id_q;
        if (s1_leave) begin
            s1b_valid_d = 1'b1;
            s1b_p_d     = prod;
            s1b_id_d    = s1_id_q;
        end else if (s2_load) begin
            s1b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1b_valid_q <= 1'b0;
            s1b_p_q     <= '0;
            s1b_id_q    <= '0;
        end else begin
            s1b_valid_q <= s1b_valid_d;
            s1b_p_q     <= s1b_p_d;
            s1b_id_q    <= s1b_id_d;
        end
    end
`else
    assign s1_leave     = s2_load;
    assign s2_src_valid = s1_valid_q;
    assign s2_src_p     = prod;
    assign s2_src_id    = s1_id_q;
`endif

    assign s2_load   = s2_src_valid & (!res_valid_q | res_ready);
    assign s1_free   = !s1_valid_q | s1_leave;
    assign accept    = s1_free & (|req_valid);
    assign req_ready = accept ? grant : '0;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        res_valid_d = res_valid_q;
        res_out_d   = res_out_q;
        res_id_d    = res_id_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = req_a[grant_id*SIZE +: SIZE];
            s1_b_d     = req_b[grant_id*SIZE +: SIZE];
            s1_id_d    = grant_id;
        end else if (s1_leave) begin
            s1_valid_d = 1'b0;
        end
        if (s2_load) begin
            res_valid_d = 1'b1;
            res_out_d   = s2_src_p;
            res_id_d    = s2_src_id;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            res_valid_q <= 1'b0;
            res_out_q   <= '0;
            res_id_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            res_valid_q <= res_valid_d;
            res_out_q   <= res_out_d;
            res_id_q    <= res_id_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_out   = res_out_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios plus random traffic against a
// queue-based model (in-order results, fixed latency, capacity-limited intake).
module tb_mult_arbiter;

    localparam int SIZE = 24;
    localparam int NR   = 4;
    localparam int IDW  = 2;
`ifdef MULT_ARBITER_PIPE_EN
    localparam int LAT  = 3;
`else
    localparam int LAT  = 2;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NR-1:0]         req_valid, req_ready;
    logic [NR*SIZE-1:0]    req_a, req_b;
    logic                  res_valid, res_ready;
    logic [2*SIZE-1:0]     res_out;
    logic [IDW-1:0]        res_id;

    always #5 clk = ~clk;

    mult_arbiter #(.SIZE(SIZE), .NUM_REQ(NR), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_out   (res_out),
        .res_id    (res_id)
    );

    typedef struct {
        logic [47:0] p;
        int          id;
        int          t;
    } exp_t;

    exp_t           q[$];
    int             mptr, edge_n, last_g;
    int             n_checks, n_errors;
    logic [SIZE-1:0] opa[NR];
    logic [SIZE-1:0] opb[NR];
    logic [NR-1:0]  pend;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [NR-1:0] v);
        for (int k = 1; k <= NR; k++)
            if (v[(mptr + k) % NR]) return (mptr + k) % NR;
        return -1;
    endfunction

    // One cycle: drive, compare against the model, then advance the model.
    task automatic step(input logic [NR-1:0] v, input logic rr);
        logic          ev, pop;
        int            g;
        exp_t          e;
        logic [NR-1:0] er;
        @(negedge clk);
        req_valid = v;
        res_ready = rr;
        for (int i = 0; i < NR; i++) begin
            req_a[i*SIZE +: SIZE] = opa[i];
            req_b[i*SIZE +: SIZE] = opb[i];
        end
        #1;
        ev = (q.size() > 0) && (edge_n - q[0].t >= LAT - 1);
        chk("res_valid", 64'(res_valid), 64'(ev));
        if (ev) begin
            chk("res_out", 64'(res_out), 64'(q[0].p));
            chk("res_id", 64'(res_id), 64'(q[0].id));
        end
        pop = ev && rr;
        g = model_pick(v);
        if (g >= 0 && !((q.size() < LAT) || pop)) g = -1;
        er = (g >= 0) ? NR'(1 << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(er));
        @(posedge clk);
        edge_n++;
        if (pop) void'(q.pop_front());
        if (g >= 0) begin
            e.p  = 48'(opa[g]) * 48'(opb[g]);
            e.id = g;
            e.t  = edge_n;
            q.push_back(e);
            mptr = g;
        end
        last_g = g;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        req_valid = '0;
        res_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_out", 64'(res_out), 64'd0);
        chk("rst_res_id", 64'(res_id), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        mptr = NR - 1;
        pend = '0;
    endtask

    initial begin
        logic [NR-1:0] v;
        logic          rr;
        n_checks  = 0;
        n_errors  = 0;
        edge_n    = 0;
        last_g    = -1;
        mptr      = NR - 1;
        pend      = '0;
        rst_n     = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NR; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        apply_reset();

        // single requester 2: 3*5
        opa[2] = 24'd3;
        opb[2] = 24'd5;
        step(4'b0100, 1'b1);
        repeat (LAT + 1) step(4'b0000, 1'b1);

        // all valid, rotating grants
        for (int i = 0; i < NR; i++) begin
            opa[i] = 24'(i + 1);
            opb[i] = 24'd10;
        end
        repeat (12) step(4'hF, 1'b1);
        repeat (LAT + 1) step(4'b0000, 1'b1);

        // consumer stalled, then drained
        repeat (5) step(4'b0011, 1'b0);
        repeat (LAT + 2) step(4'b0000, 1'b1);

        // full-width product
        opa[0] = 24'hFFFFFF;
        opb[0] = 24'hFFFFFF;
        step(4'b0001, 1'b0);
        repeat (LAT - 1) step(4'b0000, 1'b0);
        @(negedge clk);
        #1;
        chk("full_width", 64'(res_out), 64'h0000_FFFF_FE00_0001);
        repeat (3) step(4'b0000, 1'b1);

        // reset with a full pipeline
        for (int i = 0; i < NR; i++) begin
            opa[i] = 24'($urandom);
            opb[i] = 24'($urandom);
        end
        repeat (4) step(4'hF, 1'b0);
        apply_reset();
        step(4'hF, 1'b1);
        repeat (LAT + 2) step(4'b0000, 1'b1);

        // random traffic with a mid-run reset
        for (int it = 0; it < 400; it++) begin
            if (it == 200) apply_reset();
            for (int i = 0; i < NR; i++) begin
                if (pend[i]) v[i] = 1'b1;
                else begin
                    v[i] = 1'($urandom_range(0, 1));
                    if (v[i]) begin
                        opa[i] = 24'($urandom);
                        opb[i] = 24'($urandom);
                    end
                end
            end
            rr = ($urandom_range(0, 9) < 7);
            step(v, rr);
            pend = v;
            if (last_g >= 0) pend[last_g] = 1'b0;
        end
        repeat (LAT + 3) step(4'b0000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
